// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - fixed-priority (d over i) SRAM bus arbiter with in-order response routing
module sram_req_arbiter #(
    parameter int MAX_OUTST = 2,
    parameter int CNT_W     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic              i_wr,
    input  logic [1:0]        i_size,
    input  logic [31:0]       i_addr,
    input  logic [3:0]        i_wstrb,
    input  logic [31:0]       i_wdata,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [1:0]        d_size,
    input  logic [31:0]       d_addr,
    input  logic [3:0]        d_wstrb,
    input  logic [31:0]       d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [31:0]       d_rdata,
    output logic              s_req,
    output logic              s_wr,
    output logic [1:0]        s_size,
    output logic [31:0]       s_addr,
    output logic [3:0]        s_wstrb,
    output logic [31:0]       s_wdata,
    input  logic              s_addr_ok,
    input  logic              s_data_ok,
    input  logic [31:0]       s_rdata,
    output logic [CNT_W-1:0]  outst_cnt,
    output logic              err_unexp
);
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    logic [MAX_OUTST-1:0] id_q, id_d;
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic full, cnt_nz, gnt_d, gnt_i, push, pop, head_id;

    // full uses the registered count only, so a same-cycle pop never frees a slot
    always_comb begin
        cnt_nz  = (cnt_q != '0);
        full    = (cnt_q == CNT_W'(MAX_OUTST));
        gnt_d   = d_req & ~full;
        gnt_i   = i_req & ~d_req & ~full;
        push    = (gnt_d | gnt_i) & s_addr_ok;
        pop     = s_data_ok & cnt_nz;
        head_id = id_q[head_q];
    end

    always_comb begin
        s_req   = gnt_d | gnt_i;
        s_wr    = gnt_d ? d_wr    : (gnt_i ? i_wr    : 1'b0);
        s_size  = gnt_d ? d_size  : (gnt_i ? i_size  : 2'b00);
        s_addr  = gnt_d ? d_addr  : (gnt_i ? i_addr  : 32'h0);
        s_wstrb = gnt_d ? d_wstrb : (gnt_i ? i_wstrb : 4'h0);
        s_wdata = gnt_d ? d_wdata : (gnt_i ? i_wdata : 32'h0);

        d_addr_ok = gnt_d & s_addr_ok;
        i_addr_ok = gnt_i & s_addr_ok;
        d_data_ok = pop & head_id;
        i_data_ok = pop & ~head_id;
        d_rdata   = s_rdata;
        i_rdata   = s_rdata;

        outst_cnt = cnt_q;
        err_unexp = err_q;
    end

    always_comb begin
        id_d = id_q;
        if (push) begin
            id_d[tail_q] = gnt_d;
        end
        tail_d = push ? tail_q + PTR_W'(1) : tail_q;
        head_d = pop  ? head_q + PTR_W'(1) : head_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        err_d = err_q | (s_data_ok & ~cnt_nz);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_q   <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            id_q   <= id_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end
endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - scoreboard bench for sram_req_arbiter
module tb_sram_req_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_wr, d_req, d_wr;
    logic [1:0]  i_size, d_size;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic [3:0]  i_wstrb, d_wstrb;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic [31:0] i_rdata, d_rdata;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_addr_ok, s_data_ok;
    logic [1:0]  outst_cnt;
    logic        err_unexp;

    sram_req_arbiter #(.MAX_OUTST(2), .CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr),
        .i_wstrb(i_wstrb), .i_wdata(i_wdata),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
        .d_wstrb(d_wstrb), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
        .s_wstrb(s_wstrb), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .outst_cnt(outst_cnt), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_q[$];
    int mcnt;
    bit merr;
    bit last_push;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        i_req = 0; i_wr = 0; i_size = 2'd2; i_addr = 32'h0; i_wstrb = 4'h0; i_wdata = 32'h0;
        d_req = 0; d_wr = 0; d_size = 2'd2; d_addr = 32'h0; d_wstrb = 4'h0; d_wdata = 32'h0;
        s_addr_ok = 0; s_data_ok = 0; s_rdata = 32'h0;
    endtask

    task automatic model_clear();
        exp_q.delete();
        mcnt = 0;
        merr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
    endtask

    // One clock: check outputs at negedge against the model, then advance the scoreboard
    task automatic step();
        bit full, gd, gi, push, pop, hid;
        logic [31:0] ea, ew;
        logic [6:0]  ef;
        @(negedge clk);
        full = (mcnt == 2);
        gd = d_req & ~full;
        gi = i_req & ~d_req & ~full;
        ea = gd ? d_addr  : (gi ? i_addr  : 32'h0);
        ew = gd ? d_wdata : (gi ? i_wdata : 32'h0);
        ef = gd ? {d_wr, d_size, d_wstrb} : (gi ? {i_wr, i_size, i_wstrb} : 7'h0);
        check("s_req", 32'(s_req), 32'(gd | gi));
        check("s_addr", s_addr, ea);
        check("s_wdata", s_wdata, ew);
        check("s_fields", 32'({s_wr, s_size, s_wstrb}), 32'(ef));
        check("d_addr_ok", 32'(d_addr_ok), 32'(gd & s_addr_ok));
        check("i_addr_ok", 32'(i_addr_ok), 32'(gi & s_addr_ok));
        check("outst_cnt", 32'(outst_cnt), 32'(mcnt));
        check("err_unexp", 32'(err_unexp), 32'(merr));
        pop = s_data_ok && (mcnt > 0);
        if (pop) begin
            hid = exp_q[0];
            check("d_data_ok", 32'(d_data_ok), 32'(hid));
            check("i_data_ok", 32'(i_data_ok), 32'(!hid));
            check(hid ? "d_rdata" : "i_rdata", hid ? d_rdata : i_rdata, s_rdata);
        end else begin
            check("d_data_ok_idle", 32'(d_data_ok), 32'h0);
            check("i_data_ok_idle", 32'(i_data_ok), 32'h0);
        end
        push = (gd | gi) & s_addr_ok;
        last_push = push;
        if (s_data_ok && mcnt == 0) merr = 1;
        if (pop) void'(exp_q.pop_front());
        if (push) exp_q.push_back(gd);
        mcnt = mcnt + int'(push) - int'(pop);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    initial begin
        int accepted;
        bit nxt;
        reset = 1'b1;
        idle_inputs();
        model_clear();
        #12;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // idle, then unexpected response
        step(); step();
        s_data_ok = 1; s_rdata = 32'h12345678;
        step();
        s_data_ok = 0;
        step(); step();
        check("err_sticky", 32'(err_unexp), 32'h1);

        // single fetch
        do_reset();
        i_req = 1; i_addr = 32'h1C000000; s_addr_ok = 1;
        step();
        i_req = 0; s_addr_ok = 0;
        step();
        s_data_ok = 1; s_rdata = 32'hDEADBEEF;
        step();
        s_data_ok = 0;
        step();
        check("fetch_no_err", 32'(err_unexp), 32'h0);

        // both ports: d first, then i, responses in order
        do_reset();
        i_req = 1; d_req = 1; d_addr = 32'h100; i_addr = 32'h200; s_addr_ok = 1;
        d_wr = 1; d_wstrb = 4'hF; d_wdata = 32'hCAFE0001;
        step();
        d_req = 0; d_wr = 0;
        step();
        i_req = 0; s_addr_ok = 0;
        step();
        s_data_ok = 1; s_rdata = 32'hAAAA0000;
        step();
        s_rdata = 32'hBBBB0000;
        step();
        s_data_ok = 0;
        step();

        // full FIFO blocks a third request until a slot frees
        do_reset();
        d_req = 1; d_addr = 32'h300; s_addr_ok = 1;
        step(); step();
        check("cnt_full", 32'(outst_cnt), 32'h2);
        step();
        s_data_ok = 1; s_rdata = 32'h11110000;
        step();
        s_data_ok = 0;
        step();
        d_req = 0; s_addr_ok = 0;
        s_data_ok = 1; s_rdata = 32'h22220000;
        step(); step();
        s_data_ok = 0;
        step();

        // simultaneous push/pop at cnt=1, then alternating i/d traffic across pointer wrap
        do_reset();
        i_req = 1; i_addr = 32'h400; s_addr_ok = 1;
        step();
        i_req = 0; d_req = 1; d_addr = 32'h500; s_data_ok = 1; s_rdata = 32'h33330000;
        step();
        check("cnt_pushpop", 32'(outst_cnt), 32'h1);
        d_req = 0; s_addr_ok = 0; s_rdata = 32'h44440000;
        step();
        s_data_ok = 0;
        accepted = 0;
        nxt = 0;
        i_addr = 32'h1000; d_addr = 32'h2000;
        for (int cyc = 0; cyc < 300 && (accepted < 10 || mcnt > 0); cyc++) begin
            i_req = (accepted < 10) && !nxt;
            d_req = (accepted < 10) && nxt;
            s_addr_ok = 1'($urandom_range(0, 1));
            s_data_ok = (mcnt > 0) && ($urandom_range(0, 2) != 0);
            s_rdata = $urandom;
            step();
            if (last_push) begin
                accepted++;
                nxt = !nxt;
                i_addr = i_addr + 32'h4;
                d_addr = d_addr + 32'h4;
            end
        end
        idle_inputs();
        check("wrap_accepted", 32'(accepted), 32'd10);
        check("wrap_drained", 32'(outst_cnt), 32'h0);
        step();

        // async reset with two outstanding and err set
        do_reset();
        s_data_ok = 1;
        step();
        s_data_ok = 0;
        d_req = 1; d_addr = 32'h600; s_addr_ok = 1;
        step(); step();
        d_req = 0; s_addr_ok = 0;
        step();
        check("pre_reset_cnt", 32'(outst_cnt), 32'h2);
        #2 reset = 1'b1;
        #1;
        check("async_cnt", 32'(outst_cnt), 32'h0);
        check("async_err", 32'(err_unexp), 32'h0);
        model_clear();
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        s_data_ok = 1; s_rdata = 32'h55550000;
        step();
        s_data_ok = 0;
        step();
        check("stale_err", 32'(err_unexp), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
Shares the single SRAM-like bus between the instruction-fetch requester (port i) and the load/store requester (port d). Uses the req/addr_ok/data_ok split-transaction handshake. Tracks up to MAX_OUTST accepted-but-unanswered transactions in an in-order ID FIFO, and routes each data_ok/rdata back to the requester that issued it. It sits between the IF/EX/MEM stages and the SRAM bridge; the MEM stage's load data arrives through this block.

Parameters:
MAX_OUTST, 2, depth of the outstanding-transaction ID FIFO (power of 2, 2..8)
CNT_W, 2, width of the outstanding counter; must hold MAX_OUTST (log2(MAX_OUTST)+1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous active-high reset
i_req  in  1  fetch request valid
i_wr  in  1  fetch write flag (normally 0, passed through)
i_size  in  2  fetch access size
i_addr  in  32  fetch address
i_wstrb  in  4  fetch byte strobes
i_wdata  in  32  fetch write data
i_addr_ok  out  1  fetch request accepted this cycle
i_data_ok  out  1  fetch response valid this cycle
i_rdata  out  32  fetch read data
d_req, d_wr, d_size, d_addr, d_wstrb, d_wdata  in  1/1/2/32/4/32  load/store request, same meaning as the i_ fields
d_addr_ok  out  1  load/store request accepted
d_data_ok  out  1  load/store response valid (reads and writes)
d_rdata  out  32  load read data
s_req  out  1  bus request
s_wr, s_size, s_addr, s_wstrb, s_wdata  out  1/2/32/4/32  muxed request fields
s_addr_ok  in  1  bus accepted request
s_data_ok  in  1  bus response valid
s_rdata  in  32  bus read data
outst_cnt  out  CNT_W  number of outstanding transactions
err_unexp  out  1  sticky: s_data_ok received with FIFO empty

Behaviour:
- Reset (async, active-high) clears FIFO pointers, outst_cnt=0 and err_unexp=0. Everything else is combinational from state and inputs. With no requests and no s_data_ok, all outputs are 0. A reset mid-transaction discards all tracked IDs.
- full = (outst_cnt == MAX_OUTST), taken from the registered count only. A pop in the same cycle does not free a slot for a push in that cycle.
- Arbitration is fixed priority, d over i: gnt_d = d_req & ~full; gnt_i = i_req & ~d_req & ~full.
- s_req = gnt_d | gnt_i. The s_* request fields come from the granted port; when neither port is granted they are 0.
- The granted requester must hold its fields stable until addr_ok; the arbiter does not latch them.
- The grant may switch between cycles while s_addr_ok is low (d arriving preempts a pending i). This is allowed because the bus samples only on s_req & s_addr_ok.
- d_addr_ok = gnt_d & s_addr_ok; i_addr_ok = gnt_i & s_addr_ok.
- Push: on s_req & s_addr_ok, write ID (1=d, 0=i) at the tail and advance the tail pointer, wrapping modulo MAX_OUTST.
- Pop: on s_data_ok with count>0, read the head ID and advance the head pointer with the same wrap.
- Response routing:
  - d_data_ok = s_data_ok & cnt>0 & head==1; i_data_ok = s_data_ok & cnt>0 & head==0.
  - s_rdata drives both i_rdata and d_rdata unconditionally; consumers qualify with data_ok.
- Simultaneous push and pop leave outst_cnt unchanged; both pointers advance.
- s_data_ok while count==0: no pop, no data_ok to either port, err_unexp set to 1 until reset.
- Zero-latency response: a response in the same cycle as its own addr_ok is not possible by construction, since the pop reads the pre-push head. The bus must give data_ok no earlier than the cycle after addr_ok.
- Responses are strictly in order. Writes also produce data_ok and occupy a FIFO slot.

Test Plan:
- Reset, then both ports idle, then s_data_ok=1 for one cycle -> all outputs 0 until the pulse; err_unexp=1 from the next cycle on and held until reset.
- i_req=1 with i_addr=0x1C000000, s_addr_ok=1 for one cycle, s_data_ok=1 with s_rdata=0xDEADBEEF two cycles later -> s_addr=0x1C000000, i_addr_ok pulses once, outst_cnt goes 1 then 0, i_data_ok=1 with i_rdata=0xDEADBEEF, d_data_ok=0 throughout.
- i_req and d_req both high, d_addr=0x100, i_addr=0x200, s_addr_ok=1 -> d granted first (s_addr=0x100, d_addr_ok=1, i_addr_ok=0); i granted the next cycle; responses return d first, then i.
- MAX_OUTST=2, two d requests accepted, a third held high, s_data_ok held 0 -> outst_cnt=2, s_req=0, d_addr_ok=0; one s_data_ok -> cnt=1, then the third request is accepted on the following cycle.
- Push and pop in the same cycle with cnt=1 -> cnt stays 1, response routed by the old head. Run 10 alternating i/d transactions to exercise pointer wrap; every data_ok must reach its issuer in order.
- Assert reset asynchronously (mid-cycle) with cnt=2 -> outst_cnt=0 and err_unexp=0 immediately; a stale s_data_ok after reset sets err_unexp and produces no data_ok.
